butterfly_result_display: RTL

//  Downstream of the butterfly datapath on the board build. Captures one butterfly result
//  (y_re, y_im, z_re, z_im) via a valid/ready handshake. Presents one word at a time on the

---
 rtl/butterfly_pkg.sv | 18 +
 rtl/butterfly_result_display_hex_to_seg7.sv | 29 ++
 rtl/butterfly_result_display.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/butterfly_pkg.sv
// Shared types and constants for the butterfly result display block.
// Holds the display FSM state enum, result word indices and the blank 7-seg pattern.
package butterfly_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_state_t;

    localparam int WORD_Y_RE = 0;
    localparam int WORD_Y_IM = 1;
    localparam int WORD_Z_RE = 2;
    localparam int WORD_Z_IM = 3;
    localparam int NUM_WORDS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/butterfly_result_display_hex_to_seg7.sv
// Combinational 4-bit nibble to active-low 7-segment decoder.
// Segment order is {g,f,e,d,c,b,a}; a low bit lights the segment.
module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        unique case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/butterfly_result_display.sv
// Captures one butterfly result and shows its four words on the LEDs, stepped by a debounced switch.
// Optional 7-seg outputs hex0/hex1 are built when BUTTERFLY_HEX_DISPLAY_EN is defined.
module butterfly_result_display
    import butterfly_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] y_re,
    input  logic [DATA_W-1:0] y_im,
    input  logic [DATA_W-1:0] z_re,
    input  logic [DATA_W-1:0] z_im,
    input  logic              control,
    output logic [DATA_W-1:0] led,
    output logic [3:0]        sel_led
`ifdef BUTTERFLY_HEX_DISPLAY_EN
    ,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1
`endif
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    logic             deb_level;
    logic [CNT_W-1:0] deb_cnt;
    logic             adv;

    disp_state_t       state, next_state;
    logic [1:0]        idx, next_idx;
    logic              capture;
    logic [DATA_W-1:0] words [NUM_WORDS];
    logic [DATA_W-1:0] next_led;
    logic [3:0]        next_sel;

    // Two-flop synchroniser for the asynchronous switch.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= control;
            sync2 <= sync1;
        end
    end

    // Level is accepted after DEBOUNCE_CYCLES consecutive differing samples; adv marks a rise only.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
            adv       <= 1'b0;
        end else begin
            adv <= 1'b0;
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
                deb_level <= sync2;
                deb_cnt   <= '0;
                adv       <= sync2;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign res_ready = (state == IDLE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        capture    = 1'b0;
        next_led   = '0;
        next_sel   = '0;
        unique case (state)
            IDLE: begin
                if (res_valid) begin
                    capture    = 1'b1;
                    next_state = SHOW;
                    next_idx   = 2'(WORD_Y_RE);
                end
            end
            SHOW: begin
                if (adv) begin
                    if (idx == 2'(WORD_Z_IM)) begin
                        next_state = IDLE;
                        next_idx   = '0;
                    end else begin
                        next_idx = idx + 2'd1;
                    end
                end
            end
        endcase
        if (next_state == SHOW) begin
            next_led = capture ? y_re : words[next_idx];
            next_sel = 4'b0001 << next_idx;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            idx     <= '0;
            led     <= '0;
            sel_led <= '0;
        end else begin
            state   <= next_state;
            idx     <= next_idx;
            led     <= next_led;
            sel_led <= next_sel;
        end
    end

    // NOTE: the word store is reset too, so a reset mid-display leaves no stale result behind.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NUM_WORDS; i++) words[i] <= '0;
        end else if (capture) begin
            words[WORD_Y_RE] <= y_re;
            words[WORD_Y_IM] <= y_im;
            words[WORD_Z_RE] <= z_re;
            words[WORD_Z_IM] <= z_im;
        end
    end

`ifdef BUTTERFLY_HEX_DISPLAY_EN
    logic [6:0] seg_lo, seg_hi;

    hex_to_seg7 u_seg_lo (
        .nibble (next_led[3:0]),
        .seg    (seg_lo)
    );

    hex_to_seg7 u_seg_hi (
        .nibble (next_led[7:4]),
        .seg    (seg_hi)
    );

    // Decoded from next_led so the digits change on the same edge as led.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            hex0 <= SEG_BLANK;
            hex1 <= SEG_BLANK;
        end else if (next_state == SHOW) begin
            hex0 <= seg_lo;
            hex1 <= seg_hi;
        end else begin
            hex0 <= SEG_BLANK;
            hex1 <= SEG_BLANK;
        end
    end
`endif

endmodule
